clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 8: divisor and counter width per channel.
REQ-003 Local CHW = max(1, clog2(NCH)): channel-select width.
REQ-004 clk  input  1  single clock; all state changes on rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  configuration write strobe, one cycle per write.
REQ-007 cfg_ch  input  CHW  target channel of the write.
REQ-008 cfg_div  input  WIDTH  new divisor D for the target channel.
REQ-009 cfg_en  input  1  new enable for the target channel.
REQ-010 sync_restart  input  1  realign all channel counters to phase 0.
REQ-011 tick  output  NCH  per-channel one-cycle strobe, one per divided period.
REQ-012 div_out  output  NCH  per-channel registered divided square wave.
REQ-013 pending  output  NCH  per-channel flag: configuration written but not yet applied.

Function
REQ-014 Per-channel state: active divisor D, active enable EN, counter CNT (WIDTH bits), shadow divisor P, shadow enable PE, pending flag.
REQ-015 A channel is running when EN=1 and D>=2; when D=0 or EN=0 it is idle: CNT=0, tick=0, div_out=0.
REQ-016 Running: CNT increments by 1 each cycle and wraps from D-1 to 0; period is exactly D cycles.
REQ-017 tick[i] is a flop set to 1 in the cycle after CNT=D-1 (i.e. while CNT=0 after a wrap); otherwise 0.
REQ-018 div_out[i] is a flop: 1 while CNT < ceil(D/2), else 0; high ceil(D/2) cycles, low floor(D/2) cycles per period.
REQ-019 D=1 with EN=1: tick[i]=1 every cycle, div_out[i]=0, CNT held at 0.
REQ-020 Write with cfg_ch >= NCH: ignored, no state change.
REQ-021 Write to an idle channel, or to one with D=1: D<=cfg_div, EN<=cfg_en, CNT<=0 on that edge; pending stays 0; first tick occurs D cycles after the write edge.
REQ-022 Write to a running channel: P<=cfg_div, PE<=cfg_en, pending<=1; no change to D, EN, CNT.
REQ-023 Pending apply: on the edge where CNT wraps D-1 to 0, D<=P, EN<=PE, CNT<=0, pending<=0; this tick still fires; switches are glitch-free, with no truncated high or low phase.
REQ-024 Disable of a running channel is deferred per REQ-022/023; the output completes its current period, then holds 0.
REQ-025 A second write before apply overwrites P/PE; only the last write takes effect.
REQ-026 A write on the same edge as the channel's wrap is applied at that wrap, overriding any older pending value.
REQ-027 sync_restart=1: every channel CNT<=0 and tick<=0 on that edge; all pending configs are applied on that edge; sync_restart has priority over counting.
REQ-028 cfg_we together with sync_restart: the write is applied immediately to its channel, as in REQ-021.
REQ-029 Channels are fully independent except for sync_restart; a write to channel i never perturbs channel j.

Reset
REQ-030 On a clk edge with reset=1: D=0, EN=0, CNT=0, P=0, PE=0; tick=0, div_out=0, pending=0 for all channels.
REQ-031 Reset overrides cfg_we and sync_restart; a reset mid-period aborts the period, and outputs are 0 the cycle after.

Verification
REQ-032 Reset; write ch0 D=4 en=1 -> tick[0] every 4 cycles; div_out[0] is 2 high/2 low; pending[0]=0.
REQ-033 ch1 D=5 running -> div_out[1] is 3 high/2 low; tick[1] period 5; ch1 unaffected by writes to ch0.
REQ-034 ch0 D=4 running; write D=6 mid-period -> pending[0]=1 until the wrap; next periods are 6; no short pulse on div_out[0].
REQ-035 Running channel; write en=0 -> current period completes, then tick=0 and div_out=0; a second write before the wrap (D=3, en=1) instead switches to period 3.
REQ-036 ch0 D=3 and ch2 D=8 out of phase; pulse sync_restart -> both CNT=0 on the next cycle, first ticks 3 and 8 cycles later; write D=1 -> tick held high.
REQ-037 Assert reset mid-period with pending writes -> all outputs 0 next cycle; cfg_ch=NCH write ignored.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with shadowed configuration
// that is applied only at a period boundary, so the divided outputs never glitch.
module clk_div_bank #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync_restart,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   div_out,
  output logic [NCH-1:0]   pending
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d, half_c;
    logic             en_q, en_d, pen_q, pen_d, pend_q, pend_d;
    logic             tick_q, tick_d, dout_q, dout_d;
    logic             hit_c, active_c, running_c, wrap_c;

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    assign hit_c     = cfg_we && (cfg_ch == CHW'(g));
    assign active_c  = en_q && (div_q != '0);
    assign running_c = en_q && (div_q > WIDTH'(1));
    assign wrap_c    = active_c && (cnt_q == div_q - WIDTH'(1));
    assign half_c    = (div_d >> 1) + WIDTH'(div_d[0]);

    always_comb begin
      div_d  = div_q;
      en_d   = en_q;
      cnt_d  = cnt_q;
      pdiv_d = pdiv_q;
      pen_d  = pen_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      if (sync_restart) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (hit_c) begin
          div_d = cfg_div;
          en_d  = cfg_en;
        end else if (pend_q) begin
          div_d = pdiv_q;
          en_d  = pen_q;
        end
      end else if (hit_c && !running_c) begin
        // Idle or divide-by-one channels take the new setting at once.
        div_d  = cfg_div;
        en_d   = cfg_en;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (wrap_c) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        pend_d = 1'b0;
        if (hit_c) begin
          div_d = cfg_div;
          en_d  = cfg_en;
        end else if (pend_q) begin
          div_d = pdiv_q;
          en_d  = pen_q;
        end
      end else begin
        cnt_d = running_c ? cnt_q + WIDTH'(1) : '0;
        if (hit_c) begin
          pdiv_d = cfg_div;
          pen_d  = cfg_en;
          pend_d = 1'b1;
        end
      end
      // Output follows the next counter value so it is aligned with the phase.
      dout_d = en_d && (div_d > WIDTH'(1)) && (cnt_d < half_c);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        div_q  <= '0;
        en_q   <= 1'b0;
        cnt_q  <= '0;
        pdiv_q <= '0;
        pen_q  <= 1'b0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        dout_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        en_q   <= en_d;
        cnt_q  <= cnt_d;
        pdiv_q <= pdiv_d;
        pen_q  <= pen_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        dout_q <= dout_d;
      end
    end

    assign tick[g]    = tick_q;
    assign div_out[g] = dout_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a phase-arithmetic model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_clk_div_bank;
  localparam int unsigned NCH   = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHW   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [CHW-1:0]   cfg_ch = '0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic             cfg_en = 1'b0;
  logic             sync_restart = 1'b0;
  logic [NCH-1:0]   tick, div_out, pending;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] dout;
    logic [NCH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model: each channel's phase is (cycle - start) mod D.
  int m_d[NCH], m_en[NCH], m_p[NCH], m_pe[NCH], m_pend[NCH], m_start[NCH], m_tick[NCH];

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .sync_restart(sync_restart), .tick(tick), .div_out(div_out),
    .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input int i, input int d, input int en);
    m_d[i]     = d;
    m_en[i]    = en;
    m_start[i] = cyc;
  endtask

  task automatic model_edge();
    exp_t e;
    bit   hit, running, wrapping;
    int   ph;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        m_d[i] = 0; m_en[i] = 0; m_p[i] = 0; m_pe[i] = 0; m_pend[i] = 0;
        m_start[i] = cyc; m_tick[i] = 0;
      end else begin
        hit      = cfg_we && (int'(cfg_ch) == i);
        running  = (m_en[i] != 0) && (m_d[i] >= 2);
        wrapping = 1'b0;
        if (m_en[i] != 0 && m_d[i] >= 1 && cyc > m_start[i])
          wrapping = ((cyc - m_start[i]) % m_d[i]) == 0;
        if (sync_restart) begin
          m_tick[i] = 0;
          if (hit) set_cfg(i, int'(cfg_div), int'(cfg_en));
          else if (m_pend[i] != 0) set_cfg(i, m_p[i], m_pe[i]);
          else m_start[i] = cyc;
          m_pend[i] = 0;
        end else if (hit && !running) begin
          m_tick[i] = 0;
          set_cfg(i, int'(cfg_div), int'(cfg_en));
          m_pend[i] = 0;
        end else if (wrapping) begin
          m_tick[i] = 1;
          if (hit) set_cfg(i, int'(cfg_div), int'(cfg_en));
          else if (m_pend[i] != 0) set_cfg(i, m_p[i], m_pe[i]);
          else m_start[i] = cyc;
          m_pend[i] = 0;
        end else begin
          m_tick[i] = 0;
          if (hit) begin
            m_p[i] = int'(cfg_div); m_pe[i] = int'(cfg_en); m_pend[i] = 1;
          end
        end
      end
      e.tick[i] = (m_tick[i] != 0);
      e.pend[i] = (m_pend[i] != 0);
      e.dout[i] = 1'b0;
      if (m_en[i] != 0 && m_d[i] >= 2) begin
        ph = (cyc - m_start[i]) % m_d[i];
        e.dout[i] = ph < (m_d[i] + 1) / 2;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    reset = 1'b0;
    cfg_we = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int d, input int en);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_div = WIDTH'(d);
    cfg_en  = en[0];
    step();
  endtask

  function automatic void check(input string name, input logic [NCH-1:0] act,
                                input logic [NCH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tick", tick, e.tick);
      check("div_out", div_out, e.dout);
      check("pending", pending, e.pend);
    end
  end

  initial begin
    reset = 1'b1;
    idle(2);
    wr(0, 4, 1); idle(12);              // ch0 /4
    wr(1, 5, 1); idle(7);               // ch1 /5 alongside
    wr(0, 6, 1); idle(16);              // deferred switch to /6
    wr(1, 7, 0); idle(1);               // deferred disable ...
    wr(1, 3, 1); idle(12);              // ... overridden by /3
    wr(1, 5, 0); idle(10);              // disable completes the period
    wr(2, 8, 1); idle(3);
    wr(0, 3, 1);                        // pending on ch0
    sync_restart = 1'b1; step();        // realign, apply pending
    idle(10);
    sync_restart = 1'b1; wr(1, 2, 1);   // write together with restart
    idle(5);
    wr(2, 1, 1); idle(5);               // divide-by-one: tick held high
    wr(2, 4, 1); idle(6);
    wr(0, 5, 1); wr(1, 6, 1); idle(1);
    reset = 1'b1; step();               // reset mid-period with pending writes
    wr(3, 4, 1); idle(4);               // out-of-range channel ignored
    wr(0, 0, 1); wr(1, 255, 1); wr(2, 2, 1); idle(6);

    repeat (2000) begin
      reset        = ($urandom_range(0, 299) == 0);
      sync_restart = ($urandom_range(0, 49) == 0);
      cfg_we       = ($urandom_range(0, 5) == 0);
      cfg_ch       = CHW'($urandom_range(0, 3));
      cfg_div      = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 255))
                                                  : WIDTH'($urandom_range(0, 9));
      cfg_en       = ($urandom_range(0, 4) != 0);
      step();
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
